// File: rtl/hrfp_adder_stream.sv
// Radix-16 floating-point adder/subtractor: six-stage pipeline (compare, swap, align, add,
// normalise, round) with valid/ready backpressure and an opaque tag carried alongside each op.
module hrfp_adder_stream #(
   parameter  int EXP_W  = 7,
   parameter  int MANT_W = 28,
   parameter  int TAG_W  = 4,
   localparam int W      = 1 + EXP_W + MANT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     op_a,
   input  logic [W-1:0]     op_b,
   input  logic             sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     result,
   output logic [TAG_W-1:0] out_tag
);
   localparam int STAGES = 6;
   localparam int XW     = MANT_W + 4;          // mantissa plus one guard digit
   localparam int SAT    = MANT_W / 4 + 2;
   localparam int DW     = $clog2(SAT + 1);
   localparam int AW     = XW + SAT * 4;
   localparam int EW     = EXP_W + 2;           // two's complement, room for carry and underflow
   localparam int LZW    = $clog2(XW / 4 + 1);
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [EW-1:0]    EINF = EW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}};

   logic                advance;
   logic [STAGES:1]     vld_pipe;
   logic [TAG_W-1:0]    tag_q [1:STAGES-1];
   logic                spf_q [1:STAGES-1];
   logic [W-1:0]        spw_q [1:STAGES-1];

   assign out_valid = vld_pipe[STAGES];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

   // stage 1 inputs: unpack, effective sign of B, specials, magnitude compare
   logic              sa, sb, swap, spf;
   logic [EXP_W-1:0]  ea, eb;
   logic [MANT_W-1:0] ma, mb;
   logic [W-1:0]      spw;
   always_comb begin
      sa   = op_a[W-1];
      sb   = op_b[W-1] ^ sub;
      ea   = op_a[W-2 -: EXP_W];
      eb   = op_b[W-2 -: EXP_W];
      ma   = op_a[MANT_W-1:0];
      mb   = op_b[MANT_W-1:0];
      swap = {eb, mb} > {ea, ma};
      spf  = 1'b1;
      spw  = QNAN;
      if ((ea == EMAX && ma != '0) || (eb == EMAX && mb != '0) ||
          (ea == EMAX && eb == EMAX && sa != sb))
         spw = QNAN;
      else if (ea == EMAX)
         spw = {sa, EMAX, {MANT_W{1'b0}}};
      else if (eb == EMAX)
         spw = {sb, EMAX, {MANT_W{1'b0}}};
      else
         spf = 1'b0;
   end

   logic              s1_sa, s1_sb, s1_swap;
   logic [EXP_W-1:0]  s1_ea, s1_eb;
   logic [MANT_W-1:0] s1_ma, s1_mb;
   logic [EXP_W-1:0]  e2_big, e2_dif;
   always_comb begin
      e2_big = s1_swap ? s1_eb : s1_ea;
      e2_dif = e2_big - (s1_swap ? s1_ea : s1_eb);
   end

   logic              s2_s, s2_sub;
   logic [EXP_W-1:0]  s2_e;
   logic [MANT_W-1:0] s2_mbig, s2_msml;
   logic [DW-1:0]     s2_diff;
   logic [AW-1:0]     sh3;
   assign sh3 = {s2_msml, {(AW-MANT_W){1'b0}}} >> {s2_diff, 2'b00};

   logic              s3_s, s3_sub, s3_stk;
   logic [EXP_W-1:0]  s3_e;
   logic [XW-1:0]     s3_big, s3_aln;
   logic [XW:0]       sum4;
   // sticky enters as a borrow so the difference stays below the exact value
   assign sum4 = s3_sub ? ({1'b0, s3_big} - {1'b0, s3_aln} - {{XW{1'b0}}, s3_stk})
                        : ({1'b0, s3_big} + {1'b0, s3_aln});

   logic              s4_s, s4_stk;
   logic [EXP_W-1:0]  s4_e;
   logic [XW:0]       s4_sum;
   logic [XW-1:0]     nx5;
   logic              st5, hit5;
   logic [EW-1:0]     e5;
   logic [LZW-1:0]    lz5;
   always_comb begin
      nx5 = s4_sum[XW] ? s4_sum[XW:4] : s4_sum[XW-1:0];
      st5 = s4_stk | (s4_sum[XW] & (|s4_sum[3:0]));
      e5  = {{(EW-EXP_W){1'b0}}, s4_e} + {{(EW-1){1'b0}}, s4_sum[XW]};
      lz5  = '0;
      hit5 = 1'b0;
      for (int i = XW/4 - 1; i >= 0; i--) begin
         if (!hit5 && nx5[i*4 +: 4] == 4'h0) lz5 = lz5 + LZW'(1);
         else hit5 = 1'b1;
      end
   end

   logic              s5_s, s5_stk, s5_zero;
   logic [EW-1:0]     s5_e, e6;
   logic [XW-1:0]     s5_m;
   logic [MANT_W-1:0] m6, mf6;
   logic [MANT_W:0]   mr6;
   logic [3:0]        g6;
   logic              up6;
   logic [W-1:0]      res6;
   always_comb begin
      m6  = s5_m[XW-1:4];
      g6  = s5_m[3:0];
      up6 = (g6 > 4'h8) || (g6 == 4'h8 && (s5_stk || m6[0]));
      mr6 = {1'b0, m6} + {{MANT_W{1'b0}}, up6};
      e6  = s5_e + {{(EW-1){1'b0}}, mr6[MANT_W]};
      mf6 = mr6[MANT_W] ? {4'h1, {(MANT_W-4){1'b0}}} : mr6[MANT_W-1:0];
      if (spf_q[STAGES-1])
         res6 = spw_q[STAGES-1];
      else if (s5_zero || e6[EW-1])
         res6 = '0;
      else if (e6 >= EINF)
         res6 = {s5_s, EMAX, {MANT_W{1'b0}}};
      else
         res6 = {s5_s, e6[EXP_W-1:0], mf6};
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         tag_q[1] <= in_tag;
         spf_q[1] <= spf;
         spw_q[1] <= spw;
         for (int i = 2; i < STAGES; i++) begin
            tag_q[i] <= tag_q[i-1];
            spf_q[i] <= spf_q[i-1];
            spw_q[i] <= spw_q[i-1];
         end
         s1_sa   <= sa;
         s1_sb   <= sb;
         s1_ea   <= ea;
         s1_eb   <= eb;
         s1_ma   <= ma;
         s1_mb   <= mb;
         s1_swap <= swap;
         s2_s    <= s1_swap ? s1_sb : s1_sa;
         s2_sub  <= s1_sa ^ s1_sb;
         s2_e    <= e2_big;
         s2_mbig <= s1_swap ? s1_mb : s1_ma;
         s2_msml <= s1_swap ? s1_ma : s1_mb;
         s2_diff <= (e2_dif > EXP_W'(SAT)) ? DW'(SAT) : e2_dif[DW-1:0];
         s3_s    <= s2_s;
         s3_sub  <= s2_sub;
         s3_e    <= s2_e;
         s3_big  <= {s2_mbig, 4'h0};
         s3_aln  <= sh3[AW-1 -: XW];
         s3_stk  <= |sh3[AW-XW-1:0];
         s4_s    <= s3_s;
         s4_e    <= s3_e;
         s4_sum  <= sum4;
         s4_stk  <= s3_stk;
         s5_s    <= s4_s;
         s5_stk  <= st5;
         s5_zero <= (nx5 == '0);
         s5_m    <= nx5 << {lz5, 2'b00};
         s5_e    <= e5 - {{(EW-LZW){1'b0}}, lz5};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         result   <= '0;
         out_tag  <= '0;
      end else if (advance) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
         result   <= res6;
         out_tag  <= tag_q[STAGES-1];
      end
   end
endmodule

// File: tb/tb_hrfp_adder_stream.sv
// Scoreboard bench for hrfp_adder_stream: directed vectors, backpressured stream, async reset.
module tb_hrfp_adder_stream;
   logic        clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready;
   logic [35:0] op_a, op_b, result;
   logic [3:0]  in_tag, out_tag;

   hrfp_adder_stream dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .sub(sub), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
   );

   typedef struct {
      logic [35:0] res;
      logic [3:0]  tag;
      bit          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0, fails = 0, cyc = 0, stalls = 0, n_out = 0;
   bit          rdy_mode = 0;
   int          pidx = 0;
   logic [3:0]  pat = 4'b1001;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (rdy_mode) begin
         out_ready = pat[pidx];
         pidx = (pidx + 1) % 4;
      end else
         out_ready = 1'b1;
   end

   task automatic check36(input string name, input logic [35:0] act, input logic [35:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got result %h tag %h, expected none", result, out_tag);
         end else begin
            x = sb.pop_front();
            check36("result", result, x.res);
            checki("out_tag", int'(out_tag), int'(x.tag));
            if (x.lat) checki("latency", cyc - x.acc, 6);
            n_out++;
         end
      end
   end

   task automatic issue(input logic [35:0] a, input logic [35:0] b, input logic s,
                        input logic [3:0] t, input logic [35:0] e, input bit lat);
      exp_t x;
      int   g;
      @(negedge clk);
      op_a = a; op_b = b; sub = s; in_tag = t; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 100) begin
         stalls++;
         g++;
         @(negedge clk);
      end
      if (g >= 100) checki("in_ready_timeout", 0, 1);
      x.res = e; x.tag = t; x.lat = lat; x.acc = cyc;
      sb.push_back(x);
      @(posedge clk);
   endtask

   task automatic idle_and_drain();
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      checki("drain_queue_empty", sb.size(), 0);
   endtask

   initial begin
      int         base;
      logic [3:0] k4;
      rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; in_tag = '0;
      out_ready = 1'b1;
      #12;
      checki("reset_out_valid", int'(out_valid), 0);
      checki("reset_in_ready", int'(in_ready), 1);
      check36("reset_result", result, 36'h0);
      checki("reset_out_tag", int'(out_tag), 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(36'h4_1100_0000, 36'h4_1100_0000, 1'b0, 4'h3, 36'h4_1200_0000, 1);
      issue(36'h4_1100_0000, 36'h4_1100_0000, 1'b1, 4'h1, 36'h0_0000_0000, 1);
      issue(36'h4_1100_0000, 36'hC_1100_0000, 1'b0, 4'h2, 36'h0_0000_0000, 1);
      issue(36'h4_1FFF_FFFF, 36'h4_1000_0001, 1'b0, 4'h4, 36'h4_2100_0000, 1);
      issue(36'h7_EFFF_FFFF, 36'h7_E000_0001, 1'b0, 4'h5, 36'h7_F000_0000, 1);
      issue(36'h7_F800_0001, 36'h4_1100_0000, 1'b0, 4'h6, 36'h7_F800_0000, 1);
      issue(36'h7_F000_0000, 36'hF_F000_0000, 1'b0, 4'h7, 36'h7_F800_0000, 1);
      issue(36'h7_F000_0000, 36'h4_1100_0000, 1'b0, 4'h8, 36'h7_F000_0000, 1);
      issue(36'h0_0000_0000, 36'h0_0000_0000, 1'b1, 4'h9, 36'h0_0000_0000, 1);
      issue(36'h8_0000_0000, 36'h8_0000_0000, 1'b0, 4'hA, 36'h0_0000_0000, 1);
      issue(36'h4_1100_0000, 36'h4_1200_0000, 1'b1, 4'hB, 36'hC_1100_0000, 1);
      issue(36'h4_1100_0000, 36'h4_0F00_0000, 1'b1, 4'hC, 36'h4_0100_0000, 1);
      issue(36'h4_1100_0000, 36'h3_A800_0000, 1'b0, 4'hD, 36'h4_1100_0000, 1);
      issue(36'h4_1100_0001, 36'h3_A800_0000, 1'b0, 4'hE, 36'h4_1100_0002, 1);
      issue(36'h4_1100_0000, 36'h3_A800_0001, 1'b0, 4'hF, 36'h4_1100_0001, 1);
      issue(36'h4_1FFF_FFFF, 36'h3_A800_0001, 1'b0, 4'h0, 36'h4_2100_0000, 1);
      issue(36'h0_0200_0000, 36'h0_01F0_0000, 1'b1, 4'h1, 36'h0_0000_0000, 1);
      issue(36'hF_E800_0000, 36'hF_E800_0000, 1'b0, 4'h2, 36'hF_F000_0000, 1);
      issue(36'h4_1100_0000, 36'h0_1100_0000, 1'b0, 4'h3, 36'h4_1100_0000, 1);
      issue(36'h4_1100_0000, 36'h0_0000_0000, 1'b0, 4'h4, 36'h4_1100_0000, 1);
      issue(36'h7_F000_0000, 36'h7_F000_0000, 1'b1, 4'h5, 36'h7_F800_0000, 1);
      issue(36'h4_1100_0000, 36'hF_F000_0000, 1'b0, 4'h6, 36'hF_F000_0000, 1);
      idle_and_drain();

      // stream: k + 1.0 for k = 1..15, then k - 1.0 for k = 2..6, under 1,0,0,1 backpressure
      base = n_out;
      stalls = 0;
      rdy_mode = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i < 15) begin
            k4 = 4'(i + 1);
            issue({1'b0, 7'h41, k4, 24'h0}, 36'h4_1100_0000, 1'b0, 4'(i),
                  (i == 14) ? 36'h4_2100_0000 : {1'b0, 7'h41, 4'(i + 2), 24'h0}, 0);
         end else begin
            k4 = 4'(i - 13);
            issue({1'b0, 7'h41, k4, 24'h0}, 36'h4_1100_0000, 1'b1, 4'(i),
                  {1'b0, 7'h41, 4'(i - 14), 24'h0}, 0);
         end
      end
      idle_and_drain();
      rdy_mode = 1'b0;
      checki("stream_count", n_out - base, 20);
      checki("stream_stalled", int'(stalls > 0), 1);

      // async reset with ops in flight and a result on the output
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++)
         issue(36'h4_1100_0000, 36'h4_1100_0000, 1'b0, 4'(i), 36'h4_1200_0000, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      checki("pre_reset_out_valid", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      checki("async_reset_out_valid", int'(out_valid), 0);
      checki("async_reset_in_ready", int'(in_ready), 1);
      check36("async_reset_result", result, 36'h0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      checki("post_reset_no_output", int'(out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
